wide_add_seq: RTL and testbench
===============================

// Module: wide_add_seq
// PURPOSE
//  Multi-cycle wide-operand add/sub sequencer built around one adder64 instance.
//  Accepts NWORDS*64-bit operands over a valid/ready handshake and walks them
//  through the adder one 64-bit slice per cycle, LSW first, registering the
//  carry between slices. Returns the full-width result, carry-out and signed
//  overflow over a second valid/ready handshake. Sits between the ALU issue
//  logic and the result writeback path for bignum/crypto operations.
// PARAMETERS
//  NWORDS  4   number of 64-bit slices per operand; legal 1..16
//  WORD_W  64  slice width; fixed by adder64, any other value is illegal
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              asynchronous reset, active low
//  in_valid   in   1              operand request valid
//  in_ready   out  1              block accepts request (IDLE only)
//  op_sub     in   1              0: a+b+cin; 1: a-b (a + ~b + 1), cin ignored
//  cin        in   1              carry-in for add
//  a          in   NWORDS*WORD_W  operand A (unsigned / two's complement)
//  b          in   NWORDS*WORD_W  operand B
//  out_valid  out  1              result valid
//  out_ready  in   1              consumer accepts result
//  sum        out  NWORDS*WORD_W  result
//  cout       out  1              final carry; for sub 1 = no borrow (a>=b unsigned)
//  ovf        out  1              signed overflow of the full-width operation
//  busy       out  1              high in RUN or DONE
// BEHAVIOUR
//  - One clock (clk). Reset is asynchronous and active-low (rst_n).
//  - Reset (async assert, sync release): state=IDLE, idx=0, carry reg=0,
//    sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. On edge with in_valid&in_ready, capture a and b_eff
//    (b_eff = op_sub ? ~b : b). Set carry reg = op_sub ? 1 : cin, idx=0. Go RUN.
//  - RUN: adder64 gets a[idx], b_eff[idx] and carry reg.
//    Each edge: sum[idx] <= s, carry <= cout, idx++.
//    On the edge that writes idx==NWORDS-1, go DONE.
//  - Latency: accept edge T0. Slice k latches at edge T0+k+1.
//    out_valid rises at edge T0+NWORDS (NWORDS=1 -> one RUN cycle).
//  - DONE: out_valid=1, in_ready=0.
//    cout = final carry. ovf = (a_msb==b_eff_msb) & (sum_msb!=a_msb).
//    sum/cout/ovf stay stable until out_valid&out_ready.
//    On that edge: go IDLE, out_valid=0; in_ready=1 the next cycle.
//    No accept/complete overlap in the same cycle.
//  - in_valid while in_ready=0 is ignored. The requester holds a/b/op_sub only
//    until the accept edge; the block does not depend on them afterwards.
//  - sum is a register, updated slice-by-slice during RUN; consumers use it only
//    when out_valid=1. Overflow/wrap of the full width is reported via cout/ovf,
//    never saturated.
//  - idx width = max(1,$clog2(NWORDS)); idx never exceeds NWORDS-1.
//  - rst_n low mid-RUN or in DONE: operation discarded, all state/outputs
//    return to reset values immediately; no partial result ever asserts out_valid.
// TESTING
//  1. NWORDS=4, a=all ones, b=1, add, cin=0 -> sum=0, cout=1, ovf=0;
//     out_valid exactly 4 cycles after accept.
//  2. a=64'hFFFF_FFFF_FFFF_FFFF (upper words 0), b=1 -> sum word1=1,
//     word0=0, cout=0 (inter-slice carry).
//  3. sub a=7,b=5 -> sum=2, cout=1. Sub a=5,b=7 -> sum=all ones minus 1
//     (-2), cout=0, ovf=0.
//  4. a=0x7FF..F (MSB 0), b=1, add -> sum=0x800..0, ovf=1, cout=0;
//     a=0x800..0, b=1, sub -> ovf=1.
//  5. out_ready low 10 cycles in DONE -> out_valid, sum, cout held; in_ready=0;
//     pulsed in_valid ignored; after handshake in_ready=1 next cycle.
//  6. rst_n pulsed low during RUN at idx=2 -> outputs at reset values at once;
//     after release a fresh add of 3+4 -> sum=7, no stale out_valid.

Source files
------------

// File: rtl/wide_add_seq_if.sv
// Request/response bundle for the wide add/sub sequencer.
//  master: issue side (drives operands and out_ready, observes result)
//  slave : sequencer side
//  in_valid/in_ready/op_sub/cin/a/b    : operand request handshake
//  out_valid/out_ready/sum/cout/ovf    : result handshake
interface wide_add_seq_if #(
    parameter int unsigned NWORDS = 4
);
    localparam int unsigned WORD_W = 64;
    localparam int unsigned DATA_W = NWORDS * WORD_W;

    logic              in_valid;
    logic              in_ready;
    logic              op_sub;
    logic              cin;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] sum;
    logic              cout;
    logic              ovf;

    modport master (
        output in_valid, op_sub, cin, a, b, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, op_sub, cin, a, b, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/wide_add_seq.sv
// Multi-cycle wide add/sub sequencer. Walks NWORDS 64-bit slices through a
// single adder64, LSW first, carrying between slices in a register.
//  clk   : rising-edge clock
//  rst_n : asynchronous active-low reset
//  bus   : wide_add_seq_if.slave (operand request + result handshakes)
//  busy  : high while an operation is in RUN or DONE

// 64-bit adder slice with carry in/out.
module adder64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] s,
    output logic        cout
);
    assign {cout, s} = 65'(a) + 65'(b) + 65'(cin);
endmodule

module wide_add_seq #(
    parameter int unsigned NWORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    wide_add_seq_if.slave     bus,
    output logic              busy
);
    localparam int unsigned WORD_W = 64;
    localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic in_ready_q;
    logic out_valid_q;
    logic in_ready_d;
    logic out_valid_d;
    logic busy_d;

    // b_q holds the already-inverted operand for subtraction
    logic [NWORDS-1:0][WORD_W-1:0] a_q;
    logic [NWORDS-1:0][WORD_W-1:0] b_q;
    logic [NWORDS-1:0][WORD_W-1:0] sum_q;
    logic                          carry_q;
    logic [IDX_W-1:0]              idx_q;
    logic                          cout_q;
    logic                          ovf_q;

    logic              accept_c;
    logic              complete_c;
    logic              last_c;
    logic [WORD_W-1:0] slice_s;
    logic              slice_co;

    assign accept_c   = bus.in_valid & in_ready_q;
    assign complete_c = out_valid_q & bus.out_ready;
    assign last_c     = (idx_q == LAST_IDX);

    // Shared slice adder
    adder64 u_adder (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_co)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept_c)   state_d = S_RUN;
            S_RUN:  if (last_c)     state_d = S_DONE;
            S_DONE: if (complete_c) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Handshake/status outputs, decoded from the upcoming state so the
    // registered copies line up with the state register
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_d)
            S_IDLE:  in_ready_d = 1'b1;
            S_RUN:   busy_d     = 1'b1;
            S_DONE: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default: in_ready_d = 1'b1;
        endcase
    end

    // Registered handshake/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy        <= busy_d;
        end
    end

    // Operand capture and slice-by-slice accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept_c) begin
            a_q     <= bus.a;
            b_q     <= bus.op_sub ? ~bus.b : bus.b;
            carry_q <= bus.op_sub ? 1'b1 : bus.cin;
            idx_q   <= '0;
        end else if (state_q == S_RUN) begin
            sum_q[idx_q] <= slice_s;
            carry_q      <= slice_co;
            if (last_c) begin
                // Final slice: result flags frozen here until the next accept
                idx_q  <= '0;
                cout_q <= slice_co;
                ovf_q  <= (a_q[NWORDS-1][WORD_W-1] == b_q[NWORDS-1][WORD_W-1]) &&
                          (slice_s[WORD_W-1] != a_q[NWORDS-1][WORD_W-1]);
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq with an expected-result scoreboard.
module tb_wide_add_seq;
    localparam int unsigned NWORDS = 4;
    localparam int unsigned W      = NWORDS * 64;
    localparam int unsigned CW     = W + 1;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    wide_add_seq_if #(.NWORDS(NWORDS)) bus ();

    wide_add_seq #(.NWORDS(NWORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(W / 32); i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Full-width reference; overflow from carry-into-MSB xor carry-out
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic ci);
        logic [W-1:0] be;
        logic [W:0]   full;
        logic [W-1:0] low;
        logic [W:0]   c0;
        exp_t         e;
        be    = sub ? ~b : b;
        c0    = '0;
        c0[0] = sub ? 1'b1 : ci;
        full  = {1'b0, a} + {1'b0, be} + c0;
        low   = {1'b0, a[W-2:0]} + {1'b0, be[W-2:0]} + c0[W-1:0];
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = full[W] ^ low[W-1];
        return e;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic ci);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", CW'(bus.in_ready), CW'(1));
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.op_sub   = sub;
        bus.cin      = ci;
        sb.push_back(model(a, b, sub, ci));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = rand_wide();
        bus.b        = rand_wide();
        bus.op_sub   = ~sub;
        bus.cin      = ~ci;
        check("busy_after_accept", CW'(busy), CW'(1));
        check("in_ready_after_accept", CW'(bus.in_ready), CW'(0));
    endtask

    task automatic wait_result(output exp_t e);
        int lat;
        lat = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = cyc;
                break;
            end
        end
        check("latency", CW'(lat), CW'(NWORDS));
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", CW'(0), CW'(1));
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        check("sum", CW'(bus.sum), CW'(e.sum));
        check("cout", CW'(bus.cout), CW'(e.cout));
        check("ovf", CW'(bus.ovf), CW'(e.ovf));
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("out_valid_after_hs", CW'(bus.out_valid), CW'(0));
        check("in_ready_after_hs", CW'(bus.in_ready), CW'(1));
        check("busy_after_hs", CW'(busy), CW'(0));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic ci);
        exp_t e;
        send(a, b, sub, ci);
        wait_result(e);
        release_result();
    endtask

    initial begin : main
        logic [W-1:0] ones;
        logic [W-1:0] one;
        logic [W-1:0] maxpos;
        logic [W-1:0] minneg;
        exp_t         e;

        ones   = '1;
        one    = W'(1);
        maxpos = {1'b0, {(W-1){1'b1}}};
        minneg = {1'b1, {(W-1){1'b0}}};

        bus.in_valid  = 1'b0;
        bus.op_sub    = 1'b0;
        bus.cin       = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", CW'(bus.in_ready), CW'(1));
        check("rst_out_valid", CW'(bus.out_valid), CW'(0));
        check("rst_busy", CW'(busy), CW'(0));
        check("rst_sum", CW'(bus.sum), CW'(0));
        check("rst_cout", CW'(bus.cout), CW'(0));
        check("rst_ovf", CW'(bus.ovf), CW'(0));
        rst_n = 1'b1;

        // Full-width wrap: all ones + 1
        run_op(ones, one, 1'b0, 1'b0);
        // Carry across the slice 0 -> 1 boundary
        run_op(W'(64'hFFFF_FFFF_FFFF_FFFF), one, 1'b0, 1'b0);
        // Subtraction with and without borrow; cin must be ignored for sub
        run_op(W'(7), W'(5), 1'b1, 1'b0);
        run_op(W'(5), W'(7), 1'b1, 1'b1);
        // Signed overflow both directions
        run_op(maxpos, one, 1'b0, 1'b0);
        run_op(minneg, one, 1'b1, 1'b0);
        // Carry-in for add
        run_op(ones, '0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) run_op(rand_wide(), rand_wide(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Back-pressure: result held stable, new requests ignored in DONE
        send(rand_wide(), rand_wide(), 1'b0, 1'b1);
        wait_result(e);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i % 3 == 0);
            bus.a        = rand_wide();
            bus.b        = rand_wide();
            @(posedge clk);
            #1;
            check("hold_out_valid", CW'(bus.out_valid), CW'(1));
            check("hold_in_ready", CW'(bus.in_ready), CW'(0));
            check("hold_sum", CW'(bus.sum), CW'(e.sum));
            check("hold_cout", CW'(bus.cout), CW'(e.cout));
        end
        bus.in_valid = 1'b0;
        release_result();
        repeat (6) @(posedge clk);
        #1;
        check("no_ghost_busy", CW'(busy), CW'(0));
        check("no_ghost_out_valid", CW'(bus.out_valid), CW'(0));

        // Reset in the middle of RUN, after two slices have latched
        send(ones, ones, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("mid_run_busy", CW'(busy), CW'(1));
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        check("mid_rst_out_valid", CW'(bus.out_valid), CW'(0));
        check("mid_rst_busy", CW'(busy), CW'(0));
        check("mid_rst_in_ready", CW'(bus.in_ready), CW'(1));
        check("mid_rst_sum", CW'(bus.sum), CW'(0));
        check("mid_rst_cout", CW'(bus.cout), CW'(0));
        check("mid_rst_ovf", CW'(bus.ovf), CW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op(W'(3), W'(4), 1'b0, 1'b0);

        check("scoreboard_drained", CW'(sb.size()), CW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
